// File: rtl/fifo_chain_if.sv
// fifo_chain_if: handshake and status bundle for the fifo_chain buffer.
//
// Signals:
//   d_in        write data from the producer
//   d_in_strobe write request from the producer
//   wr_ready    write will be accepted this cycle (combinational)
//   q           head element data
//   q_valid     head element occupied
//   rd_strobe   pop request from the consumer
//   count       number of occupied elements
//   almost_full count has reached the almost-full threshold
//   overflow    sticky: write attempted while not ready
//   underflow   sticky: read attempted while head empty
//
// The master modport is the side that writes and reads the FIFO;
// the slave modport is the FIFO itself.
interface fifo_chain_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
);
    logic [WIDTH-1:0] d_in;
    logic             d_in_strobe;
    logic             wr_ready;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             rd_strobe;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    modport master (
        output d_in, d_in_strobe, rd_strobe,
        input  wr_ready, q, q_valid, count, almost_full, overflow, underflow
    );

    modport slave (
        input  d_in, d_in_strobe, rd_strobe,
        output wr_ready, q, q_valid, count, almost_full, overflow, underflow
    );
endinterface

// File: rtl/fifo_chain.sv
// fifo_chain: chained-element FIFO built from DEPTH storage elements.
// Element 0 is the entry, element DEPTH-1 is the head that drives q.
// Words ripple one element per cycle toward the head and stop once the
// element ahead of them is occupied, so order is strictly preserved.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset, overrides everything
//   flush  synchronous clear of contents and sticky error flags
//   bus    fifo_chain_if.slave: write side (d_in, d_in_strobe, wr_ready),
//          read side (q, q_valid, rd_strobe) and status (count,
//          almost_full, overflow, underflow)
module fifo_chain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 4,
    parameter int AFULL = 6
) (
    input logic          clk,
    input logic          reset,
    input logic          flush,
    fifo_chain_if.slave  bus
);

    logic [DEPTH-1:0] used;
    logic [DEPTH-1:0] mv;
    logic [DEPTH-1:0] fill;
    logic [WIDTH-1:0] data [DEPTH];
    logic             pop;
    logic             accept;
    logic             wr_ready;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next;
    logic             almost_full_r;
    logic             overflow_r;
    logic             underflow_r;

    // The move chain is resolved from the head backward: an element may
    // advance when the one ahead is empty or is itself leaving this cycle.
    // Kept in a function so the bit-to-bit dependency stays local and does
    // not look like a combinational loop on a signal.
    function automatic logic [DEPTH-1:0] move_chain(input logic [DEPTH-1:0] u,
                                                    input logic             rd);
        logic [DEPTH-1:0] m;
        m            = '0;
        m[DEPTH-1]   = rd & u[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            m[i] = u[i] & (~u[i+1] | m[i+1]);
        end
        return m;
    endfunction

    // Decode this cycle's moves, the write acceptance and the element
    // fills; fill[i] marks an element that receives a word at the edge.
    always_comb begin
        mv         = move_chain(used, bus.rd_strobe);
        pop        = mv[DEPTH-1];
        wr_ready   = ~used[0] | mv[0];
        accept     = bus.d_in_strobe & wr_ready;
        fill       = '0;
        fill[0]    = accept;
        for (int i = 1; i < DEPTH; i++) begin
            fill[i] = mv[i-1];
        end
        count_next = count_r + CW'(accept) - CW'(pop);
    end

    // Flush behaves exactly like reset, so requests arriving in the same
    // cycle are dropped and do not raise the sticky flags.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            used <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
            count_r       <= '0;
            almost_full_r <= 1'b0;
            overflow_r    <= 1'b0;
            underflow_r   <= 1'b0;
        end else begin
            if (accept) begin
                data[0] <= bus.d_in;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (mv[i-1]) begin
                    data[i] <= data[i-1];
                end
            end
            used          <= fill | (used & ~mv);
            count_r       <= count_next;
            almost_full_r <= (count_next >= CW'(AFULL));
            overflow_r    <= overflow_r | (bus.d_in_strobe & ~wr_ready);
            underflow_r   <= underflow_r | (bus.rd_strobe & ~used[DEPTH-1]);
        end
    end

    assign bus.wr_ready    = wr_ready;
    assign bus.q           = data[DEPTH-1];
    assign bus.q_valid     = used[DEPTH-1];
    assign bus.count       = count_r;
    assign bus.almost_full = almost_full_r;
    assign bus.overflow    = overflow_r;
    assign bus.underflow   = underflow_r;

endmodule

// File: tb/tb_fifo_chain.sv
// tb_fifo_chain: self-checking bench for fifo_chain (WIDTH=8, DEPTH=8).
// The reference model keeps the stored words in a queue together with the
// element position of each word; every cycle each word steps one position
// toward the head unless the slot ahead is still taken by an older word.
module tb_fifo_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int AFULL = 6;

    logic clk;
    logic reset;
    logic flush;

    fifo_chain_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    fifo_chain #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CW   (CW),
        .AFULL(AFULL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [WIDTH-1:0] mdat [$];
    int               mpos [$];
    bit               movf;
    bit               munf;
    bit               exp_wr_ready;
    logic             obs_wr_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_qv();
        return (mpos.size() > 0) && (mpos[0] == DEPTH - 1);
    endfunction

    // Drives one cycle of inputs, samples wr_ready before the edge,
    // then advances the model across the edge.
    task automatic step(input logic ws, input logic [WIDTH-1:0] d,
                        input logic rs, input logic fl, input logic rst);
        int  npos [$];
        int  occ;
        int  p;
        bit  pop;
        bit  hv;
        @(negedge clk);
        bus.d_in_strobe = ws;
        bus.d_in        = d;
        bus.rd_strobe   = rs;
        flush           = fl;
        reset           = rst;
        hv  = model_qv();
        pop = rs && hv;
        occ = DEPTH;
        for (int i = 0; i < mpos.size(); i++) begin
            if (!(i == 0 && pop)) begin
                p = mpos[i];
                if (p + 1 < DEPTH && p + 1 != occ) p = p + 1;
                npos.push_back(p);
                occ = p;
            end
        end
        exp_wr_ready = (occ != 0);
        #1;
        obs_wr_ready = bus.wr_ready;
        @(posedge clk);
        if (rst || fl) begin
            mdat.delete();
            mpos.delete();
            movf = 1'b0;
            munf = 1'b0;
        end else begin
            if (pop) void'(mdat.pop_front());
            mpos = npos;
            if (ws && exp_wr_ready) begin
                mpos.push_back(0);
                mdat.push_back(d);
            end
            if (ws && !exp_wr_ready) movf = 1'b1;
            if (rs && !hv) munf = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.q !== 8'h00 || bus.q_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_head got q=%h qv=%b want q=00 qv=0", bus.q, bus.q_valid);
        end
        checks++;
        if (bus.count !== 4'd0 || bus.almost_full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_count got count=%0d af=%b want 0 0", bus.count, bus.almost_full);
        end
        checks++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got ovf=%b unf=%b want 0 0", bus.overflow, bus.underflow);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_wr_ready got %b want 1", obs_wr_ready);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 7; j++) begin
            checks++;
            if (bus.q_valid !== 1'b0 || obs_wr_ready !== 1'b1 || bus.count !== 4'd1) begin
                errors++;
                $display("[TB] FAIL single_ripple_%0d got qv=%b rdy=%b count=%0d want 0 1 1",
                         j, bus.q_valid, obs_wr_ready, bus.count);
            end
            idle(1);
        end
        checks++;
        if (bus.q_valid !== 1'b1 || bus.q !== 8'hAA || bus.count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL single_arrival got qv=%b q=%h count=%0d want 1 aa 1",
                     bus.q_valid, bus.q, bus.count);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.q_valid !== 1'b0 || bus.count !== 4'd0 || bus.underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_read got qv=%b count=%0d unf=%b want 0 0 0",
                     bus.q_valid, bus.count, bus.underflow);
        end
    endtask

    task automatic test_fill_overflow_drain();
        logic exp_af;
        do_reset();
        for (int j = 1; j <= 8; j++) begin
            step(1'b1, 8'(j), 1'b0, 1'b0, 1'b0);
            exp_af = (j >= 6);
            checks++;
            if (obs_wr_ready !== 1'b1 || bus.count !== 4'(j) || bus.almost_full !== exp_af) begin
                errors++;
                $display("[TB] FAIL fill_%0d got rdy=%b count=%0d af=%b want 1 %0d %b",
                         j, obs_wr_ready, bus.count, bus.almost_full, j, exp_af);
            end
        end
        step(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_wr_ready !== 1'b0 || bus.overflow !== 1'b1 || bus.count !== 4'd8) begin
            errors++;
            $display("[TB] FAIL overflow got rdy=%b ovf=%b count=%0d want 0 1 8",
                     obs_wr_ready, bus.overflow, bus.count);
        end
        for (int j = 1; j <= 8; j++) begin
            checks++;
            if (bus.q_valid !== 1'b1 || bus.q !== 8'(j)) begin
                errors++;
                $display("[TB] FAIL drain_%0d got qv=%b q=%h want 1 %h", j, bus.q_valid, bus.q, 8'(j));
            end
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (bus.count !== 4'd0 || bus.q_valid !== 1'b0 || bus.almost_full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_empty got count=%0d qv=%b af=%b want 0 0 0",
                     bus.count, bus.q_valid, bus.almost_full);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int j = 0; j < 8; j++) step(1'b1, 8'(8'h10 + j), 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 20; j++) begin
            checks++;
            if (bus.q_valid !== 1'b1 || bus.q !== 8'(8'h10 + j)) begin
                errors++;
                $display("[TB] FAIL b2b_out_%0d got qv=%b q=%h want 1 %h",
                         j, bus.q_valid, bus.q, 8'(8'h10 + j));
            end
            step(1'b1, 8'(8'h18 + j), 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_wr_ready !== 1'b1 || bus.count !== 4'd8 || bus.overflow !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_state_%0d got rdy=%b count=%0d ovf=%b want 1 8 0",
                         j, obs_wr_ready, bus.count, bus.overflow);
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.underflow !== 1'b1 || bus.count !== 4'd0 || bus.q_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underflow_set got unf=%b count=%0d qv=%b want 1 0 0",
                     bus.underflow, bus.count, bus.q_valid);
        end
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle(7);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.underflow !== 1'b1 || bus.count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL underflow_sticky got unf=%b count=%0d want 1 0", bus.underflow, bus.count);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underflow_flush got unf=%b want 0", bus.underflow);
        end
    endtask

    task automatic test_flush();
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) step(1'b1, 8'(8'h40 + j), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.count !== 4'd0 || bus.q_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_clear got count=%0d qv=%b ovf=%b unf=%b want 0 0 0 0",
                     bus.count, bus.q_valid, bus.overflow, bus.underflow);
        end
        idle(1);
        checks++;
        if (obs_wr_ready !== 1'b1 || bus.count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL flush_after got rdy=%b count=%0d want 1 0", obs_wr_ready, bus.count);
        end
    endtask

    task automatic test_reset_mid_ripple();
        do_reset();
        step(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 8'h23, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.count !== 4'd0 || bus.q_valid !== 1'b0 || bus.q !== 8'h00 ||
            bus.almost_full !== 1'b0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset got count=%0d qv=%b q=%h af=%b ovf=%b unf=%b want all 0",
                     bus.count, bus.q_valid, bus.q, bus.almost_full, bus.overflow, bus.underflow);
        end
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        idle(6);
        checks++;
        if (bus.q_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_early got qv=%b want 0", bus.q_valid);
        end
        idle(1);
        checks++;
        if (bus.q_valid !== 1'b1 || bus.q !== 8'h55 || bus.count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL midreset_emerge got qv=%b q=%h count=%0d want 1 55 1",
                     bus.q_valid, bus.q, bus.count);
        end
    endtask

    task automatic test_random();
        int   wr_pct;
        int   rd_pct;
        logic ws;
        logic rs;
        logic fl;
        logic [WIDTH-1:0] d;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) begin
                wr_pct = $urandom_range(10, 95);
                rd_pct = $urandom_range(10, 95);
            end
            ws = ($urandom_range(0, 99) < wr_pct);
            rs = ($urandom_range(0, 99) < rd_pct);
            fl = ($urandom_range(0, 149) == 0);
            d  = WIDTH'($urandom);
            step(ws, d, rs, fl, 1'b0);
            checks++;
            if (obs_wr_ready !== exp_wr_ready) begin
                errors++;
                $display("[TB] FAIL rnd_wr_ready c=%0d got %b want %b", c, obs_wr_ready, exp_wr_ready);
            end
            checks++;
            if (bus.count !== 4'(mdat.size()) || bus.almost_full !== (mdat.size() >= AFULL)) begin
                errors++;
                $display("[TB] FAIL rnd_count c=%0d got count=%0d af=%b want %0d %b",
                         c, bus.count, bus.almost_full, mdat.size(), (mdat.size() >= AFULL));
            end
            checks++;
            if (bus.q_valid !== model_qv() || (model_qv() && bus.q !== mdat[0])) begin
                errors++;
                $display("[TB] FAIL rnd_head c=%0d got qv=%b q=%h want qv=%b q=%h",
                         c, bus.q_valid, bus.q, model_qv(), model_qv() ? mdat[0] : 8'h00);
            end
            checks++;
            if (bus.overflow !== movf || bus.underflow !== munf) begin
                errors++;
                $display("[TB] FAIL rnd_flags c=%0d got ovf=%b unf=%b want %b %b",
                         c, bus.overflow, bus.underflow, movf, munf);
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        flush           = 1'b0;
        bus.d_in        = '0;
        bus.d_in_strobe = 1'b0;
        bus.rd_strobe   = 1'b0;
        movf            = 1'b0;
        munf            = 1'b0;
        test_reset();
        test_single_write();
        test_fill_overflow_drain();
        test_back_to_back();
        test_underflow();
        test_flush();
        test_reset_mid_ripple();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
